// File: rtl/sdram_arbiter_if.sv
// Signal bundle between two requesters, the arbiter and sdram_module.
// master: the arbiter's view; slave: the surrounding requesters and memory.
interface sdram_arbiter_if #(
    parameter int unsigned ADDR_W = 22,
    parameter int unsigned DATA_W = 16
);
    logic              A_WrEN_Sig;
    logic              A_RdEN_Sig;
    logic [ADDR_W-1:0] A_Addr;
    logic [DATA_W-1:0] A_WrData;
    logic              A_Done_Sig;
    logic [DATA_W-1:0] A_RdData;

    logic              B_WrEN_Sig;
    logic              B_RdEN_Sig;
    logic [ADDR_W-1:0] B_Addr;
    logic [DATA_W-1:0] B_WrData;
    logic              B_Done_Sig;
    logic [DATA_W-1:0] B_RdData;

    logic              WrEN_Sig;
    logic              RdEN_Sig;
    logic [ADDR_W-1:0] BRC_Addr;
    logic [DATA_W-1:0] WrData;
    logic [DATA_W-1:0] RdData;
    logic              Done_Sig;
    logic              Busy_Sig;
    logic [1:0]        Grant;
    logic              Err_Sig;

    modport master (
        input  A_WrEN_Sig, A_RdEN_Sig, A_Addr, A_WrData,
        output A_Done_Sig, A_RdData,
        input  B_WrEN_Sig, B_RdEN_Sig, B_Addr, B_WrData,
        output B_Done_Sig, B_RdData,
        output WrEN_Sig, RdEN_Sig, BRC_Addr, WrData, Grant, Err_Sig,
        input  RdData, Done_Sig, Busy_Sig
    );

    modport slave (
        output A_WrEN_Sig, A_RdEN_Sig, A_Addr, A_WrData,
        input  A_Done_Sig, A_RdData,
        output B_WrEN_Sig, B_RdEN_Sig, B_Addr, B_WrData,
        input  B_Done_Sig, B_RdData,
        input  WrEN_Sig, RdEN_Sig, BRC_Addr, WrData, Grant, Err_Sig,
        output RdData, Done_Sig, Busy_Sig
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one sdram_module between requesters A and B,
// with a per-access timeout watchdog and a sticky error flag.
module sdram_arbiter #(
    parameter int unsigned ADDR_W = 22,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TO_CYC = 4096
) (
    input logic           CLK,
    input logic           RSTn,
    sdram_arbiter_if.master bus
);
    localparam int unsigned CNT_W = $clog2(TO_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYC - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StAck, StRelease} state_t;

    state_t            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        grant_q, grant_d;
    logic              a_done_q, a_done_d;
    logic              b_done_q, b_done_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              err_q, err_d;
    logic              last_b_q, last_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic req_a, req_b, pick_b;

    assign req_a  = bus.A_WrEN_Sig | bus.A_RdEN_Sig;
    assign req_b  = bus.B_WrEN_Sig | bus.B_RdEN_Sig;
    // With both requesting, serve whichever was not served last
    assign pick_b = req_b & (~req_a | ~last_b_q);

    always_comb begin
        state_d   = state_q;
        wr_en_d   = wr_en_q;
        rd_en_d   = rd_en_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        grant_d   = grant_q;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        err_d     = err_q;
        last_b_d  = last_b_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if ((req_a | req_b) && !bus.Busy_Sig) begin
                    grant_d = pick_b ? 2'b10 : 2'b01;
                    addr_d  = pick_b ? bus.B_Addr : bus.A_Addr;
                    wdata_d = pick_b ? bus.B_WrData : bus.A_WrData;
                    // An illegal Wr+Rd request is executed as a write
                    wr_en_d = pick_b ? bus.B_WrEN_Sig : bus.A_WrEN_Sig;
                    rd_en_d = pick_b ? ~bus.B_WrEN_Sig : ~bus.A_WrEN_Sig;
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (bus.Done_Sig) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    if (rd_en_q) begin
                        if (grant_q[1]) b_rdata_d = bus.RdData;
                        else            a_rdata_d = bus.RdData;
                    end
                    b_done_d = grant_q[1];
                    a_done_d = grant_q[0];
                    state_d  = StAck;
                end else if (cnt_q == CNT_MAX) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    err_d   = 1'b1;
                    if (grant_q[1]) b_rdata_d = '0;
                    else            a_rdata_d = '0;
                    b_done_d = grant_q[1];
                    a_done_d = grant_q[0];
                    state_d  = StAck;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StAck: begin
                last_b_d = grant_q[1];
                grant_d  = 2'b00;
                state_d  = StRelease;
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= StIdle;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            grant_q   <= 2'b00;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            err_q     <= 1'b0;
            last_b_q  <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            grant_q   <= grant_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            err_q     <= err_d;
            last_b_q  <= last_b_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.WrEN_Sig   = wr_en_q;
    assign bus.RdEN_Sig   = rd_en_q;
    assign bus.BRC_Addr   = addr_q;
    assign bus.WrData     = wdata_q;
    assign bus.Grant      = grant_q;
    assign bus.A_Done_Sig = a_done_q;
    assign bus.B_Done_Sig = b_done_q;
    assign bus.A_RdData   = a_rdata_q;
    assign bus.B_RdData   = b_rdata_q;
    assign bus.Err_Sig    = err_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a transaction-level reference model checked
// every cycle, a simple sdram_module stand-in and literal spot checks.
module tb_sdram_arbiter;
    localparam int unsigned ADDR_W = 22;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TO_CYC = 4096;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    int   total = 0;
    int   bad = 0;

    sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TO_CYC(TO_CYC)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // sdram_module stand-in: Done after mem_lat idle cycles, or never when withheld
    logic [15:0] mem [int];
    int          mem_lat = 2;
    bit          withhold = 1'b0;
    int          mem_cnt = 0;
    logic        mem_done = 1'b0;
    logic [15:0] mem_rdata = 16'h0;

    assign bus.Done_Sig = mem_done;
    assign bus.RdData   = mem_rdata;

    always @(negedge CLK) begin
        if (!(bus.WrEN_Sig || bus.RdEN_Sig) || mem_done) begin
            mem_done = 1'b0;
            mem_cnt  = 0;
        end else if (!withhold) begin
            if (mem_cnt >= mem_lat) begin
                mem_done = 1'b1;
                if (bus.WrEN_Sig) mem[int'(bus.BRC_Addr)] = bus.WrData;
                else mem_rdata = mem.exists(int'(bus.BRC_Addr)) ? mem[int'(bus.BRC_Addr)] : 16'h0;
            end else begin
                mem_cnt++;
            end
        end
    end

    // Reference model: one transaction record, timed by absolute cycle numbers
    int          cyc = 0;
    bit          started = 1'b0;
    bit          m_act = 1'b0, m_own_b = 1'b0, m_wr = 1'b0, m_last_b = 1'b1;
    int          m_start = 0, m_ack_at = -1, m_free_at = 0;
    logic        m_wr_en = 0, m_rd_en = 0, m_a_done = 0, m_b_done = 0, m_err = 0;
    logic [21:0] m_addr = 0;
    logic [15:0] m_wdata = 0, m_a_rd = 0, m_b_rd = 0;
    logic [1:0]  m_grant = 0;
    bit          ra, rb;

    always @(posedge CLK) begin
        cyc++;
        ra = bus.A_WrEN_Sig | bus.A_RdEN_Sig;
        rb = bus.B_WrEN_Sig | bus.B_RdEN_Sig;
        if (!RSTn) begin
            started = 1'b1;
            m_act = 0; m_last_b = 1; m_free_at = cyc + 1; m_ack_at = -1;
            m_wr_en = 0; m_rd_en = 0; m_a_done = 0; m_b_done = 0; m_err = 0;
            m_addr = 0; m_wdata = 0; m_a_rd = 0; m_b_rd = 0; m_grant = 0;
        end else begin
            m_a_done = 0;
            m_b_done = 0;
            if (cyc == m_ack_at) begin
                m_grant  = 0;
                m_last_b = m_own_b;
            end
            if (m_act) begin
                if (bus.Done_Sig || (cyc - m_start == int'(TO_CYC))) begin
                    m_act = 0; m_wr_en = 0; m_rd_en = 0;
                    m_ack_at = cyc + 1; m_free_at = cyc + 3;
                    if (m_own_b) m_b_done = 1; else m_a_done = 1;
                    if (!bus.Done_Sig) begin
                        m_err = 1;
                        if (m_own_b) m_b_rd = 0; else m_a_rd = 0;
                    end else if (!m_wr) begin
                        if (m_own_b) m_b_rd = bus.RdData; else m_a_rd = bus.RdData;
                    end
                end
            end else if (cyc >= m_free_at && !bus.Busy_Sig && (ra || rb)) begin
                m_own_b = rb && !(ra && m_last_b);
                m_wr    = m_own_b ? bus.B_WrEN_Sig : bus.A_WrEN_Sig;
                m_wr_en = m_wr;
                m_rd_en = !m_wr;
                m_addr  = m_own_b ? bus.B_Addr : bus.A_Addr;
                m_wdata = m_own_b ? bus.B_WrData : bus.A_WrData;
                m_grant = m_own_b ? 2'b10 : 2'b01;
                m_start = cyc;
                m_act   = 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            check("cycle_ctl",
                  {bus.WrEN_Sig, bus.RdEN_Sig, bus.Grant, bus.A_Done_Sig, bus.B_Done_Sig,
                   bus.Err_Sig, bus.BRC_Addr},
                  {m_wr_en, m_rd_en, m_grant, m_a_done, m_b_done, m_err, m_addr});
            check("cycle_data", {bus.WrData, bus.A_RdData, bus.B_RdData},
                  {m_wdata, m_a_rd, m_b_rd});
        end
    end

    // Grant log: one entry per new ownership
    logic [1:0] glog [$];
    logic [1:0] prev_grant = 2'b00;
    always @(negedge CLK) begin
        if (bus.Grant != 2'b00 && prev_grant == 2'b00) glog.push_back(bus.Grant);
        prev_grant = bus.Grant;
    end

    task automatic req(input bit is_b, input bit wr, input logic [21:0] addr,
                       input logic [15:0] data, output logic [15:0] rd);
        bit seen = 1'b0;
        @(negedge CLK);
        if (is_b) begin
            bus.B_WrEN_Sig = wr; bus.B_RdEN_Sig = !wr; bus.B_Addr = addr; bus.B_WrData = data;
        end else begin
            bus.A_WrEN_Sig = wr; bus.A_RdEN_Sig = !wr; bus.A_Addr = addr; bus.A_WrData = data;
        end
        for (int i = 0; i < 10000 && !seen; i++) begin
            @(negedge CLK);
            if (is_b ? bus.B_Done_Sig : bus.A_Done_Sig) seen = 1'b1;
        end
        if (is_b) begin
            bus.B_WrEN_Sig = 0; bus.B_RdEN_Sig = 0;
        end else begin
            bus.A_WrEN_Sig = 0; bus.A_RdEN_Sig = 0;
        end
        rd = is_b ? bus.B_RdData : bus.A_RdData;
        check(is_b ? "b_done_seen" : "a_done_seen", 64'(seen), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
    endtask

    initial begin
        logic [15:0] ra_d, rb_d, dummy;
        int          cnt;
        bit          seen;
        logic [1:0]  alt_exp [6];

        bus.A_WrEN_Sig = 0; bus.A_RdEN_Sig = 0; bus.A_Addr = 0; bus.A_WrData = 0;
        bus.B_WrEN_Sig = 0; bus.B_RdEN_Sig = 0; bus.B_Addr = 0; bus.B_WrData = 0;
        bus.Busy_Sig = 0;
        mem[100] = 16'hBEEF;
        mem[200] = 16'h0005;

        // Reset state and a single A write
        do_reset();
        check("rst_grant", bus.Grant, 2'b00);
        check("rst_en", {bus.WrEN_Sig, bus.RdEN_Sig}, 2'b00);
        check("rst_err", bus.Err_Sig, 1'b0);
        check("rst_a_rd", bus.A_RdData, 16'h0);
        bus.A_WrEN_Sig = 1; bus.A_Addr = 0; bus.A_WrData = 16'h1248;
        @(negedge CLK);
        check("wr_en", bus.WrEN_Sig, 1'b1);
        check("wr_addr", bus.BRC_Addr, 22'h0);
        check("wr_data", bus.WrData, 16'h1248);
        check("wr_grant", bus.Grant, 2'b01);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge CLK);
            if (bus.A_Done_Sig) seen = 1;
        end
        bus.A_WrEN_Sig = 0;
        check("wr_done", 64'(seen), 64'd1);
        @(negedge CLK);
        check("wr_done_1cyc", bus.A_Done_Sig, 1'b0);
        check("wr_grant_clr", bus.Grant, 2'b00);

        // Simultaneous reads straight after reset: A first
        do_reset();
        glog.delete();
        fork
            req(1'b0, 1'b0, 22'd100, 16'h0, ra_d);
            req(1'b1, 1'b0, 22'd200, 16'h0, rb_d);
        join
        check("rr_a_data", ra_d, 16'hBEEF);
        check("rr_b_data", rb_d, 16'h0005);
        check("rr_count", glog.size(), 2);
        if (glog.size() == 2) begin
            check("rr_first", glog[0], 2'b01);
            check("rr_second", glog[1], 2'b10);
        end

        // Busy holds off a B request for 100 cycles
        repeat (3) @(negedge CLK);
        bus.Busy_Sig = 1;
        bus.B_RdEN_Sig = 1; bus.B_Addr = 22'd200;
        cnt = 0;
        repeat (100) begin
            @(negedge CLK);
            if (bus.WrEN_Sig || bus.RdEN_Sig || bus.Grant != 2'b00) cnt++;
        end
        check("busy_no_grant", cnt, 0);
        bus.Busy_Sig = 0;
        @(negedge CLK);
        check("busy_grant", bus.Grant, 2'b10);
        check("busy_rd_en", bus.RdEN_Sig, 1'b1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge CLK);
            if (bus.B_Done_Sig) seen = 1;
        end
        bus.B_RdEN_Sig = 0;
        check("busy_done", 64'(seen), 64'd1);
        check("busy_b_data", bus.B_RdData, 16'h0005);

        // Watchdog: memory never answers an A read
        repeat (3) @(negedge CLK);
        withhold = 1;
        bus.A_RdEN_Sig = 1; bus.A_Addr = 22'd100;
        cnt = 0; seen = 0;
        for (int i = 0; i < int'(TO_CYC) + 50 && !seen; i++) begin
            @(negedge CLK);
            if (bus.RdEN_Sig) cnt++;
            if (bus.A_Done_Sig) seen = 1;
        end
        bus.A_RdEN_Sig = 0;
        withhold = 0;
        check("to_done", 64'(seen), 64'd1);
        check("to_en_cycles", cnt, TO_CYC);
        check("to_err", bus.Err_Sig, 1'b1);
        check("to_a_rd_zero", bus.A_RdData, 16'h0);
        check("to_b_rd_kept", bus.B_RdData, 16'h0005);
        req(1'b0, 1'b1, 22'd5, 16'h00AA, dummy);
        check("to_err_sticky", bus.Err_Sig, 1'b1);

        // Reset in the middle of an access
        mem_lat = 10;
        @(negedge CLK);
        bus.B_WrEN_Sig = 1; bus.B_Addr = 22'd200; bus.B_WrData = 16'hDEAD;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (bus.WrEN_Sig) seen = 1;
        end
        check("mid_issue", 64'(seen), 64'd1);
        @(negedge CLK);
        RSTn = 0;
        @(negedge CLK);
        check("mid_rst_en", {bus.WrEN_Sig, bus.RdEN_Sig}, 2'b00);
        check("mid_rst_grant", bus.Grant, 2'b00);
        check("mid_rst_done", {bus.A_Done_Sig, bus.B_Done_Sig}, 2'b00);
        check("mid_rst_err", bus.Err_Sig, 1'b0);
        bus.B_WrEN_Sig = 0;
        RSTn = 1;
        mem_lat = 2;
        req(1'b0, 1'b0, 22'd200, 16'h0, ra_d);
        check("post_rst_a_rd", ra_d, 16'h0005);

        // Both keep requesting: A was served last, so B leads and they alternate
        glog.delete();
        alt_exp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        fork
            begin
                for (int i = 0; i < 3; i++) req(1'b0, 1'b1, 22'(10 + i), 16'(i), ra_d);
            end
            begin
                for (int j = 0; j < 3; j++) req(1'b1, 1'b1, 22'(20 + j), 16'(j), rb_d);
            end
        join
        check("alt_count", glog.size(), 6);
        for (int k = 0; k < 6 && k < glog.size(); k++) check("alt_order", glog[k], alt_exp[k]);

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "time limit");
    end
endmodule
